sprot_stim_gen: RTL

- Upstream stimulus stage for the sprot protocol checker.
- Accepts burst requests over a valid/ready handshake and drives the checker's start, a and b inputs with the protocol sequence: start, then a one cycle later, then b one cycle after that.
- Supports deliberate protocol-violation injection.
- Counts the xfer_end and prot_err responses the checker returns during each burst and reports them when the burst completes.

---
 rtl/sprot_pkg.sv | 38 +++
 rtl/sprot_sat_cnt.sv | 33 +++
 rtl/sprot_stim_gen.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sprot_pkg.sv
// Shared types and defaults for the sprot stimulus generator.
// Holds the FSM state encoding, the injection-mode encoding, parameter
// defaults and small decode helpers for the injection mode.
package sprot_pkg;

  localparam int unsigned LEN_W_DEF     = 8;
  localparam int unsigned GAP_CYC_DEF   = 2;
  localparam int unsigned DRAIN_CYC_DEF = 4;
  localparam int unsigned CNT_W_DEF     = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_A_PH  = 3'd2,
    S_B_PH  = 3'd3,
    S_GAP   = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    INJ_NONE    = 2'd0,
    INJ_DROP_A  = 2'd1,
    INJ_DROP_B  = 2'd2,
    INJ_DROP_AB = 2'd3
  } inj_e;

  // True when the injection mode suppresses the a phase.
  function automatic logic drops_a(input inj_e m);
    return (m == INJ_DROP_A) || (m == INJ_DROP_AB);
  endfunction

  // True when the injection mode suppresses the b phase.
  function automatic logic drops_b(input inj_e m);
    return (m == INJ_DROP_B) || (m == INJ_DROP_AB);
  endfunction

endpackage

// File: rtl/sprot_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (async active-high), clr_i (clear, has priority),
//        inc_i (increment, sticks at all-ones), cnt_o (current count).
module sprot_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, increment stops at the maximum value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sprot_stim_gen.sv
// Burst stimulus generator for the sprot protocol checker.
// Accepts a burst request (req_valid/req_ready, req_len, req_inj), then
// drives start / a / b for each transfer with optional phase dropping,
// counts xfer_end / prot_err responses over the burst and reports them
// with a one-cycle done pulse (done_xfers / done_errs hold until the next
// acceptance). busy covers the cycle after acceptance through DONE.
module sprot_stim_gen
  import sprot_pkg::*;
#(
  parameter int unsigned LEN_W     = LEN_W_DEF,
  parameter int unsigned GAP_CYC   = GAP_CYC_DEF,
  parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [LEN_W-1:0] req_len,
  input  logic [1:0]       req_inj,
  output logic             start,
  output logic             a,
  output logic             b,
  input  logic             prot_err,
  input  logic             xfer_end,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] done_xfers,
  output logic [CNT_W-1:0] done_errs
);

  localparam int unsigned CYC_MAX = (GAP_CYC > DRAIN_CYC) ? GAP_CYC : DRAIN_CYC;
  localparam int unsigned CYC_W   = (CYC_MAX < 2) ? 1 : $clog2(CYC_MAX);

  state_e           state_q, state_d;
  inj_e             inj_q, inj_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             start_q, a_q, b_q, busy_q, done_q, ready_q;
  logic             accept;
  logic             in_window;

  // ready_q mirrors "state is IDLE", so it doubles as the handshake qualifier.
  assign accept    = req_valid && ready_q;
  assign in_window = state_q inside {S_START, S_A_PH, S_B_PH, S_GAP, S_DRAIN};

  // Next-state logic; cyc counts down the remaining GAP/DRAIN cycles.
  always_comb begin
    state_d = state_q;
    inj_d   = inj_q;
    rem_d   = rem_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          rem_d   = req_len;
          inj_d   = inj_e'(req_inj);
          state_d = (req_len == '0) ? S_DONE : S_START;
        end
      end
      S_START: state_d = S_A_PH;
      S_A_PH:  state_d = S_B_PH;
      S_B_PH: begin
        rem_d = rem_q - LEN_W'(1);
        if (rem_q != LEN_W'(1)) begin
          if (GAP_CYC > 0) begin
            state_d = S_GAP;
            cyc_d   = CYC_W'(GAP_CYC - 1);
          end else begin
            state_d = S_START;
          end
        end else if (DRAIN_CYC > 0) begin
          state_d = S_DRAIN;
          cyc_d   = CYC_W'(DRAIN_CYC - 1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_GAP: begin
        if (cyc_q == '0) state_d = S_START;
        else             cyc_d   = cyc_q - CYC_W'(1);
      end
      S_DRAIN: begin
        if (cyc_q == '0) state_d = S_DONE;
        else             cyc_d   = cyc_q - CYC_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      inj_q   <= INJ_NONE;
      rem_q   <= '0;
      cyc_q   <= '0;
      start_q <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      inj_q   <= inj_d;
      rem_q   <= rem_d;
      cyc_q   <= cyc_d;
      start_q <= (state_d == S_START);
      a_q     <= (state_d == S_A_PH) && !drops_a(inj_d);
      b_q     <= (state_d == S_B_PH) && !drops_b(inj_d);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      ready_q <= (state_d == S_IDLE);
    end
  end

  // Response counters: cleared on acceptance, counting only inside the burst window.
  sprot_sat_cnt #(.CNT_W(CNT_W)) u_cnt_xfer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .inc_i (in_window && xfer_end),
    .cnt_o (done_xfers)
  );

  sprot_sat_cnt #(.CNT_W(CNT_W)) u_cnt_err (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .inc_i (in_window && prot_err),
    .cnt_o (done_errs)
  );

  assign req_ready = ready_q;
  assign start     = start_q;
  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
